// File: rtl/cache_miss_handler_if.sv
// Bundle of the CPU request/response, cache-array lookup/fill and
// next-level memory ports driven or observed by cache_miss_handler.
interface cache_miss_handler_if #(
    parameter int ADDR_W = 32,
    parameter int B      = 4
);
    localparam int DATA_W = B * 8;
    localparam int TAG_W  = ADDR_W - $clog2(B);

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;

    logic [TAG_W-1:0]  lookup_tag_o;
    logic              lookup_hit_i;
    logic [DATA_W-1:0] lookup_data_i;
    logic              victim_valid_i;
    logic              victim_dirty_i;
    logic [TAG_W-1:0]  victim_tag_i;
    logic [DATA_W-1:0] victim_data_i;
    logic              fill_en_o;
    logic              fill_sel_hit_o;
    logic [TAG_W-1:0]  fill_tag_o;
    logic [DATA_W-1:0] fill_data_o;
    logic              fill_dirty_o;

    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic              mem_req_we_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic [DATA_W-1:0] mem_req_wdata_o;
    logic              mem_resp_valid_i;
    logic [DATA_W-1:0] mem_resp_data_i;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  lookup_hit_i, lookup_data_i,
        input  victim_valid_i, victim_dirty_i, victim_tag_i, victim_data_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, lookup_tag_o,
        output fill_en_o, fill_sel_hit_o, fill_tag_o, fill_data_o, fill_dirty_o,
        output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output lookup_hit_i, lookup_data_i,
        output victim_valid_i, victim_dirty_i, victim_tag_i, victim_data_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, lookup_tag_o,
        input  fill_en_o, fill_sel_hit_o, fill_tag_o, fill_data_o, fill_dirty_o,
        input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o
    );
endinterface

// File: rtl/cache_miss_handler.sv
// One-request-at-a-time sequencer for a fully associative cache: lookup,
// dirty-victim writeback, refill or write-allocate, response, statistics.
module cache_miss_handler #(
    parameter int ADDR_W = 32,
    parameter int B      = 4,
    parameter int TAG_W  = ADDR_W - $clog2(B),
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    cache_miss_handler_if.master bus,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] wb_cnt_o
);
    localparam int DATA_W = B * 8;
    localparam int OFF_W  = $clog2(B);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        WB_REQ  = 3'd2,
        RF_REQ  = 3'd3,
        RF_WAIT = 3'd4,
        FILL    = 3'd5,
        RESP    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  vtag_q, vtag_d;
    logic [DATA_W-1:0] vdata_q, vdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;

    logic              resp_valid_s;
    logic              fill_en_s;
    logic              mem_valid_s;
    logic              unused_off_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Offset bits select a byte within the single-word line and carry no meaning here.
    assign unused_off_s = ^bus.req_addr_i[OFF_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            tag_q      <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            vtag_q     <= '0;
            vdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            tag_q      <= tag_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            vtag_q     <= vtag_d;
            vdata_q    <= vdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        tag_d      = tag_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        vtag_d     = vtag_q;
        vdata_d    = vdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;

        bus.req_ready_o     = 1'b0;
        resp_valid_s        = 1'b0;
        bus.resp_rdata_o    = '0;
        bus.lookup_tag_o    = (state_q == IDLE) ? '0 : tag_q;
        fill_en_s           = 1'b0;
        bus.fill_sel_hit_o  = 1'b0;
        bus.fill_tag_o      = '0;
        bus.fill_data_o     = '0;
        bus.fill_dirty_o    = 1'b0;
        mem_valid_s         = 1'b0;
        bus.mem_req_we_o    = 1'b0;
        bus.mem_req_addr_o  = '0;
        bus.mem_req_wdata_o = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    tag_d   = bus.req_addr_i[ADDR_W-1:OFF_W];
                    wdata_d = bus.req_wdata_i;
                    state_d = LOOKUP;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                if (bus.lookup_hit_i) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    state_d   = RESP;
                    if (we_q) begin
                        fill_en_s          = 1'b1;
                        bus.fill_sel_hit_o = 1'b1;
                        bus.fill_tag_o     = tag_q;
                        bus.fill_data_o    = wdata_q;
                        bus.fill_dirty_o   = 1'b1;
                    end else begin
                        data_d = bus.lookup_data_i;
                    end
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    // The victim is only stable until the next fill, so capture it now.
                    if (bus.victim_valid_i && bus.victim_dirty_i) begin
                        vtag_d  = bus.victim_tag_i;
                        vdata_d = bus.victim_data_i;
                        state_d = WB_REQ;
                    end else if (we_q) begin
                        state_d = FILL;
                    end else begin
                        state_d = RF_REQ;
                    end
                end
            end
            WB_REQ: begin
                mem_valid_s         = 1'b1;
                bus.mem_req_we_o    = 1'b1;
                bus.mem_req_addr_o  = {vtag_q, {OFF_W{1'b0}}};
                bus.mem_req_wdata_o = vdata_q;
                if (bus.mem_req_ready_i) begin
                    wb_cnt_d = sat_inc(wb_cnt_q);
                    state_d  = we_q ? FILL : RF_REQ;
                end else begin
                    state_d = WB_REQ;
                end
            end
            RF_REQ: begin
                mem_valid_s        = 1'b1;
                bus.mem_req_addr_o = {tag_q, {OFF_W{1'b0}}};
                if (bus.mem_req_ready_i) begin
                    state_d = RF_WAIT;
                end else begin
                    state_d = RF_REQ;
                end
            end
            RF_WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    data_d  = bus.mem_resp_data_i;
                    state_d = FILL;
                end else begin
                    state_d = RF_WAIT;
                end
            end
            FILL: begin
                // A store overwrites the whole line, so it allocates without a refill.
                fill_en_s        = 1'b1;
                bus.fill_tag_o   = tag_q;
                bus.fill_data_o  = we_q ? wdata_q : data_q;
                bus.fill_dirty_o = we_q;
                state_d          = RESP;
            end
            RESP: begin
                resp_valid_s     = 1'b1;
                bus.resp_rdata_o = we_q ? '0 : data_q;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are squashed while reset is sampled so an aborted transaction has no side effects.
    assign bus.resp_valid_o    = resp_valid_s & ~rst;
    assign bus.fill_en_o       = fill_en_s & ~rst;
    assign bus.mem_req_valid_o = mem_valid_s & ~rst;

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: directed vector table, reset/saturation
// sequences, and random transactions against a per-transaction model.
module tb_cache_miss_handler;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 30;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;
    int tests = 0;
    int fails = 0;
    int m_hit, m_miss, m_wb;

    always #5 clk = ~clk;

    cache_miss_handler_if #(.ADDR_W(AW), .B(4)) bus ();

    cache_miss_handler #(.ADDR_W(AW), .B(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          hit;
        logic [DW-1:0] hdata;
        logic          vv;
        logic          vd;
        logic [TW-1:0] vtag;
        logic [DW-1:0] vdata;
        int            stall;
        int            rdly;
        logic [DW-1:0] mdata;
        int            e_lat;
        logic [DW-1:0] e_rdata;
        logic          e_wb;
        logic [AW-1:0] e_wb_addr;
        logic          e_rf;
        logic [AW-1:0] e_rf_addr;
        logic          e_fill;
        logic          e_fhit;
        logic [TW-1:0] e_ftag;
        logic [DW-1:0] e_fdata;
        logic          e_fdirty;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Reference: transaction outcome straight from the lookup/writeback/refill rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic wb, rf;
        wb = !v.hit && v.vv && v.vd;
        rf = !v.hit && !v.we;
        r.e_lat     = v.hit ? 2 : 3 + (wb ? v.stall + 1 : 0) + (rf ? v.stall + 1 + v.rdly : 0);
        r.e_rdata   = v.we ? 32'h0 : (v.hit ? v.hdata : v.mdata);
        r.e_wb      = wb;
        r.e_wb_addr = {v.vtag, 2'b00};
        r.e_rf      = rf;
        r.e_rf_addr = {v.addr[31:2], 2'b00};
        r.e_fill    = v.we || !v.hit;
        r.e_fhit    = v.hit;
        r.e_ftag    = v.addr[31:2];
        r.e_fdata   = v.we ? v.wdata : v.mdata;
        r.e_fdirty  = v.we;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
        bus.lookup_hit_i = 1'b0; bus.lookup_data_i = '0;
        bus.victim_valid_i = 1'b0; bus.victim_dirty_i = 1'b0; bus.victim_tag_i = '0; bus.victim_data_i = '0;
        bus.mem_req_ready_i = 1'b0; bus.mem_resp_valid_i = 1'b0; bus.mem_resp_data_i = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
    endtask

    task automatic run_txn(input vec_t v);
        int wb_n = 0, rf_n = 0, rf_done = 0, fill_n = 0, fill_cyc = 0, resp_cyc = -1, cyc = 1;
        logic [AW-1:0] wb_addr = '0, rf_addr = '0;
        logic [DW-1:0] wb_data = '0, resp_data = '0, fdata = '0;
        logic [TW-1:0] ftag = '0;
        logic fsel = 1'b0, fdirty = 1'b0, unstable = 1'b0, tagbad = 1'b0, done = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_we_i = v.we; bus.req_addr_i = v.addr; bus.req_wdata_i = v.wdata;
        bus.lookup_hit_i = v.hit; bus.lookup_data_i = v.hdata;
        bus.victim_valid_i = v.vv; bus.victim_dirty_i = v.vd; bus.victim_tag_i = v.vtag; bus.victim_data_i = v.vdata;
        bus.mem_req_ready_i = 1'b0; bus.mem_resp_valid_i = 1'b0; bus.mem_resp_data_i = v.mdata;
        chk("req_ready_idle", bus.req_ready_o, 1);
        @(negedge clk);
        bus.req_valid_i = 1'b0; bus.req_we_i = ~v.we; bus.req_addr_i = ~v.addr; bus.req_wdata_i = ~v.wdata;
        while (!done && cyc <= 80) begin
            if (bus.lookup_tag_o !== v.addr[31:2]) tagbad = 1'b1;
            if (bus.fill_en_o) begin
                fill_n++; fill_cyc = cyc; fsel = bus.fill_sel_hit_o;
                ftag = bus.fill_tag_o; fdata = bus.fill_data_o; fdirty = bus.fill_dirty_o;
            end
            if (bus.mem_req_valid_o && bus.mem_req_we_o) begin
                if (wb_n == 0) begin
                    wb_addr = bus.mem_req_addr_o; wb_data = bus.mem_req_wdata_o;
                end else if (wb_addr !== bus.mem_req_addr_o || wb_data !== bus.mem_req_wdata_o) begin
                    unstable = 1'b1;
                end
                wb_n++;
                bus.mem_req_ready_i = (wb_n > v.stall);
            end else if (bus.mem_req_valid_o) begin
                if (rf_n == 0) rf_addr = bus.mem_req_addr_o;
                else if (rf_addr !== bus.mem_req_addr_o) unstable = 1'b1;
                rf_n++;
                bus.mem_req_ready_i = (rf_n > v.stall);
                if (rf_n > v.stall && rf_done == 0) rf_done = cyc;
            end else begin
                bus.mem_req_ready_i = 1'b0;
            end
            bus.mem_resp_valid_i = (rf_done > 0) && (cyc == rf_done + v.rdly);
            if (bus.resp_valid_o) begin
                resp_cyc = cyc; resp_data = bus.resp_rdata_o; done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("resp_seen", done, 1);
        chk("post_resp", {bus.resp_valid_o, bus.req_ready_o, bus.lookup_tag_o}, {1'b0, 1'b1, 30'h0});
        idle_inputs();
        chk("latency", resp_cyc, v.e_lat);
        chk("rdata", resp_data, v.e_rdata);
        chk("wb_issued", wb_n > 0, v.e_wb);
        if (v.e_wb) chk("wb_addr_data", {wb_addr, wb_data}, {v.e_wb_addr, v.vdata});
        chk("rf_issued", rf_n > 0, v.e_rf);
        if (v.e_rf) chk("rf_addr", rf_addr, v.e_rf_addr);
        chk("fill_count", fill_n, v.e_fill ? 1 : 0);
        if (v.e_fill) begin
            chk("fill_fields", {fsel, ftag, fdata, fdirty}, {v.e_fhit, v.e_ftag, v.e_fdata, v.e_fdirty});
            chk("fill_cycle", fill_cyc, v.e_fhit ? 1 : v.e_lat - 1);
        end
        chk("mem_req_stable", unstable, 0);
        chk("lookup_tag", tagbad, 0);
        if (v.hit) m_hit = sat(m_hit);
        else m_miss = sat(m_miss);
        if (!v.hit && v.vv && v.vd) m_wb = sat(m_wb);
        chk("counters", {hit_cnt, miss_cnt, wb_cnt}, {m_hit[CW-1:0], m_miss[CW-1:0], m_wb[CW-1:0]});
    endtask

    vec_t tbl[7];
    vec_t rv;
    logic bad;

    initial begin
        tbl[0] = '{1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0, 0, 3, 32'hDEADBEEF,
                   7, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 30'h40, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 30'h0, 32'h0, 0, 1, 32'h0,
                   2, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0};
        tbl[2] = '{1'b1, 32'h200, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b1, 30'h10, 32'hAAAA5555, 4, 1, 32'h0,
                   8, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 30'h80, 32'h12345678, 1'b1};
        tbl[3] = '{1'b1, 32'h300, 32'hCAFEF00D, 1'b1, 32'h77777777, 1'b1, 1'b1, 30'h5, 32'h1, 0, 1, 32'h0,
                   2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 30'hC0, 32'hCAFEF00D, 1'b1};
        tbl[4] = '{1'b0, 32'h10F, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 30'h3FF, 32'h11112222, 1, 2, 32'h55667788,
                   9, 32'h55667788, 1'b1, 32'hFFC, 1'b1, 32'h10C, 1'b1, 1'b0, 30'h43, 32'h55667788, 1'b0};
        tbl[5] = '{1'b0, 32'h404, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 30'h9, 32'h9, 0, 1, 32'h0F0F0F0F,
                   5, 32'h0F0F0F0F, 1'b0, 32'h0, 1'b1, 32'h404, 1'b1, 1'b0, 30'h101, 32'h0F0F0F0F, 1'b0};
        tbl[6] = '{1'b1, 32'h7FF, 32'h0BADCAFE, 1'b0, 32'h0, 1'b0, 1'b1, 30'h2, 32'h2, 2, 1, 32'h0,
                   3, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 30'h1FF, 32'h0BADCAFE, 1'b1};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        #1;
        chk("rst_strobes", {bus.req_ready_o, bus.resp_valid_o, bus.fill_en_o, bus.mem_req_valid_o}, 4'b1000);
        chk("rst_data_zero", |{bus.resp_rdata_o, bus.lookup_tag_o, bus.fill_tag_o, bus.fill_data_o,
                               bus.fill_dirty_o, bus.fill_sel_hit_o, bus.mem_req_we_o,
                               bus.mem_req_addr_o, bus.mem_req_wdata_o}, 0);
        chk("rst_counters", {hit_cnt, miss_cnt, wb_cnt}, 12'h0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Reset sampled in RF_REQ must drop the memory request at once.
        do_reset();
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h500;
        @(negedge clk); bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("rf_req_before_rst", bus.mem_req_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("mreq_drop_on_rst", bus.mem_req_valid_o, 0);
        @(negedge clk); rst = 1'b0;

        // Reset in RF_WAIT, then a late memory response must be ignored.
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h600;
        @(negedge clk); bus.req_valid_i = 1'b0;
        @(negedge clk); bus.mem_req_ready_i = 1'b1;
        @(negedge clk); bus.mem_req_ready_i = 1'b0;
        chk("miss_before_rst", miss_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.mem_resp_valid_i = 1'b1; bus.mem_resp_data_i = 32'h99999999;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.mem_resp_valid_i = 1'b0;
            if (bus.fill_en_o || bus.resp_valid_o || bus.mem_req_valid_o || !bus.req_ready_o) bad = 1'b1;
        end
        chk("abort_quiet", bad, 0);
        chk("abort_counters", {hit_cnt, miss_cnt, wb_cnt}, 12'h0);
        m_hit = 0; m_miss = 0; m_wb = 0;

        // Push hit_cnt to all-ones and beyond.
        for (int i = 0; i < CMAX + 3; i++) run_txn(tbl[1]);
        chk("hit_saturated", hit_cnt, CMAX);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            rv = tbl[0];
            rv.we = 1'($urandom); rv.addr = $urandom; rv.wdata = $urandom;
            rv.hit = ($urandom_range(0, 2) == 0); rv.hdata = $urandom;
            rv.vv = 1'($urandom); rv.vd = 1'($urandom); rv.vtag = 30'($urandom); rv.vdata = $urandom;
            rv.stall = $urandom_range(0, 3); rv.rdly = $urandom_range(1, 4); rv.mdata = $urandom;
            run_txn(model(rv));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Sequencing controller between the CPU request port and the fully associative cache array; it also drives the next-level memory port.
- Accepts one CPU load/store at a time and performs the tag lookup against the array.
- On a hit it returns data or updates the line. On a miss it writes back a dirty victim, refills or allocates the line, then responds.
- Keeps saturating hit, miss and writeback counters for performance monitoring.

Parameters:
- ADDR_W, 32, CPU/memory address width.
- B, 4, line size in bytes. One line is one data word, DATA_W = B*8.
- TAG_W, ADDR_W-$clog2(B), tag width.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid_i  in  1  CPU request valid
- req_ready_o  out  1  CPU request ready; high only in IDLE
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  store data, full line
- resp_valid_o  out  1  one-cycle completion pulse for both loads and stores
- resp_rdata_o  out  DATA_W  load data, valid with resp_valid_o
- lookup_tag_o  out  TAG_W  tag presented to the array
- lookup_hit_i  in  1  array hit, combinational from lookup_tag_o
- lookup_data_i  in  DATA_W  hit-way data
- victim_valid_i  in  1  LRU victim valid bit
- victim_dirty_i  in  1  LRU victim dirty bit
- victim_tag_i  in  TAG_W  LRU victim tag
- victim_data_i  in  DATA_W  LRU victim data
- fill_en_o  out  1  one-cycle array write strobe
- fill_sel_hit_o  out  1  1 = write hit way, 0 = write LRU victim way
- fill_tag_o  out  TAG_W  tag to write
- fill_data_o  out  DATA_W  data to write
- fill_dirty_o  out  1  dirty bit to write; valid bit is always written 1
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory request ready
- mem_req_we_o  out  1  1 = writeback, 0 = line read
- mem_req_addr_o  out  ADDR_W  line address, offset bits zero
- mem_req_wdata_o  out  DATA_W  writeback data
- mem_resp_valid_i  in  1  read data valid
- mem_resp_data_i  in  DATA_W  read data
- hit_cnt_o, miss_cnt_o, wb_cnt_o  out  CNT_W each  statistics counters

Behaviour:
- Reset (synchronous, checked first):
  - State goes to IDLE; all counters clear to 0.
  - Outputs after reset: req_ready_o=1; resp_valid_o=0; fill_en_o=0; mem_req_valid_o=0; all data, address and tag outputs 0.
  - Reset mid-operation abandons the transaction. mem_req_valid_o drops in the same cycle reset is sampled. No fill and no response is issued.
- States: IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT, FILL, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch we/addr/wdata, go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP:
  - lookup_tag_o = latched addr[ADDR_W-1:$clog2(B)]. lookup_tag_o holds this value in every state except IDLE.
  - Load hit: latch lookup_data_i into the response register, hit_cnt+1, go to RESP.
  - Store hit: fill_en_o=1, fill_sel_hit_o=1, data = wdata, dirty=1 in this same cycle; hit_cnt+1; go to RESP.
  - Miss: miss_cnt+1. Victim valid and dirty goes to WB_REQ, latching victim tag and data. Otherwise go to FILL for a store, RF_REQ for a load.
- WB_REQ:
  - mem_req_valid_o=1, we=1, addr = {victim_tag, zeros}, wdata = victim data.
  - Address, data and valid hold stable until mem_req_ready_i.
  - On the handshake: wb_cnt+1, then go to FILL for a store, RF_REQ for a load.
- RF_REQ:
  - mem_req_valid_o=1, we=0, addr = {tag, zeros}; hold until mem_req_ready_i, then go to RF_WAIT.
- RF_WAIT:
  - Wait indefinitely for mem_resp_valid_i; latch mem_resp_data_i, go to FILL.
  - mem_resp_valid_i is ignored in every other state.
- FILL:
  - fill_en_o=1, fill_sel_hit_o=0, fill_tag_o = request tag, go to RESP.
  - Load: data = refill data, dirty=0.
  - Store: data = wdata, dirty=1 (write-allocate, no refill because the line is a full word).
- RESP:
  - resp_valid_o=1 for one cycle; resp_rdata_o = latched data for loads, 0 for stores.
  - Go to IDLE. There is no back-pressure on the response.
- Latency (request handshake at cycle 0):
  - Hit: resp_valid_o at cycle 2.
  - Clean store miss: cycle 3.
  - Load miss: at least 5 cycles, plus memory stalls.
- Counters saturate at all-ones and never wrap.
- The array only changes on fill_en_o, so victim_* signals are sampled in LOOKUP only.
- Request address offset bits are ignored.

Test Plan:
- Reset, then load 0x100 into an empty array:
  - LOOKUP sees a miss; RF_REQ issues addr 0x100, we=0.
  - Memory returns 0xDEADBEEF after 3 cycles.
  - Fill is clean with tag 0x40; resp_rdata_o=0xDEADBEEF; miss_cnt=1.
- Load 0x100 again with lookup_hit_i=1 and lookup_data_i=0xDEADBEEF:
  - resp_valid_o 2 cycles after the handshake; hit_cnt=1; no mem_req_valid_o.
- Store 0x200 with data 0x12345678 on a miss, victim valid+dirty, tag 0x10, data 0xAAAA5555:
  - Writeback to 0x40 with 0xAAAA5555, held through 4 cycles of mem_req_ready_i=0.
  - No refill; fill dirty=1 with 0x12345678; wb_cnt=1.
- Store hit to 0x300:
  - fill_en_o with fill_sel_hit_o=1 and dirty=1 in the LOOKUP cycle; resp 2 cycles after the handshake.
- Assert rst in RF_WAIT, then pulse mem_resp_valid_i the next cycle:
  - No fill and no response; state is IDLE; counters are 0.
- Preload hit_cnt near all-ones and drive 3 hits:
  - hit_cnt stays at all-ones.
